// File: rtl/bram_read_streamer_pkg.sv
// bram_read_streamer_pkg: width helper and parameter legality check shared by the read streamer files
package bram_read_streamer_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic bit params_ok(input int latency, input int fifo_depth);
        return (latency == 1 || latency == 2) && fifo_depth >= latency + 1 &&
               (fifo_depth & (fifo_depth - 1)) == 0;
    endfunction

endpackage

// File: rtl/bram_read_streamer_if.sv
// bram_read_streamer_if: request and response valid/ready streams of the BRAM read streamer
interface bram_read_streamer_if #(
    parameter int RAM_WIDTH  = 64,
    parameter int ADDR_WIDTH = 9
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [RAM_WIDTH-1:0]  resp_data;

    modport master (
        output req_valid, req_addr, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_addr, resp_ready,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/bram_read_streamer_stream_fifo_reg.sv
// stream_fifo_reg: register-based circular FIFO exposing occupancy count and head data
module stream_fifo_reg
    import bram_read_streamer_pkg::*;
#(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int PW    = clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [PW:0]      count,
    output logic [WIDTH-1:0] head
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;

    assign head = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PW'(pop);
            wr_ptr <= wr_ptr + PW'(push);
            count  <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/bram_read_streamer.sv
// bram_read_streamer: streams BRAM reads, absorbing the RAM read latency in a credit-guarded FIFO
module bram_read_streamer
    import bram_read_streamer_pkg::*;
#(
    parameter int RAM_WIDTH  = 64,
    parameter int ADDR_WIDTH = 9,
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    bram_read_streamer_if.slave   bus,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    output logic                  ram_enb,
    output logic                  ram_regceb,
    input  logic [RAM_WIDTH-1:0]  ram_doutb
);
    localparam int PW = clog2(FIFO_DEPTH);

    if (!params_ok(LATENCY, FIFO_DEPTH)) begin : g_bad_params
        $error("bram_read_streamer: LATENCY must be 1 or 2 and FIFO_DEPTH a power of two >= LATENCY+1");
    end

    logic [LATENCY:1] v;
    logic [PW:0]      count;
    logic [PW:0]      inflight;
    logic             fire;
    logic             push;
    logic             pop;

    assign fire       = bus.req_valid & bus.req_ready;
    assign push       = v[LATENCY];
    assign pop        = bus.resp_valid & bus.resp_ready;
    assign inflight   = (PW+1)'($countones(v));
    // Credit counts reads already in the RAM pipe, so the FIFO can never overflow
    assign bus.req_ready  = reset_n & (({1'b0, inflight} + {1'b0, count}) < (PW+2)'(FIFO_DEPTH));
    assign bus.resp_valid = count != '0;
    assign busy       = (|v) | (|count);
    assign ram_addrb  = bus.req_addr;
    assign ram_enb    = fire;
    assign ram_regceb = LATENCY == 2 ? v[1] : 1'b0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) v <= '0;
        else v <= (v << 1) | LATENCY'(fire);
    end

    stream_fifo_reg #(
        .WIDTH (RAM_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     (ram_doutb),
        .count   (count),
        .head    (bus.resp_data)
    );
endmodule

// File: tb/tb_bram_read_streamer.sv
// tb_bram_read_streamer: randomized checks of LATENCY=2 and LATENCY=1 streamers against a queue model
module tb_bram_read_streamer;
    localparam int RW = 64, AW = 9, DEPTH = 4;

    logic          clock = 0;
    logic          reset_n = 0;
    logic          req_valid = 0;
    logic          resp_ready = 0;
    logic [AW-1:0] req_addr = '0;
    logic [RW-1:0] mem [2**AW];
    int            checks = 0;
    int            errors = 0;
    longint        ec = 0;

    always #5 clock = ~clock;
    always @(posedge clock) ec <= ec + 1;

    task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = g == 0 ? 2 : 1;
        bram_read_streamer_if #(.RAM_WIDTH(RW), .ADDR_WIDTH(AW)) bus ();
        logic          busy, ram_enb, ram_regceb;
        logic [AW-1:0] ram_addrb;
        logic [RW-1:0] ram_a, ram_b, ram_doutb;
        logic [RW-1:0] exp_q [$];
        longint        due_q [$];
        int            fires = 0;
        logic          prev_fire = 0;
        logic          exp_valid, exp_fire;

        assign bus.req_valid  = req_valid;
        assign bus.req_addr   = req_addr;
        assign bus.resp_ready = resp_ready;

        always @(posedge clock) begin
            if (ram_enb) ram_a <= mem[ram_addrb];
            if (ram_regceb) ram_b <= ram_a;
        end
        assign ram_doutb = LAT == 2 ? ram_b : ram_a;

        bram_read_streamer #(
            .RAM_WIDTH(RW), .ADDR_WIDTH(AW), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)
        ) u_dut (
            .clock      (clock),
            .reset_n    (reset_n),
            .bus        (bus),
            .busy       (busy),
            .ram_addrb  (ram_addrb),
            .ram_enb    (ram_enb),
            .ram_regceb (ram_regceb),
            .ram_doutb  (ram_doutb)
        );

        function automatic string tag(input string s);
            return $sformatf("L%0d %s", LAT, s);
        endfunction

        // Outstanding reads = fired minus popped; each becomes visible LAT+1 cycles after its fire
        always @(negedge clock) begin
            if (!reset_n) begin
                exp_q.delete();
                due_q.delete();
                prev_fire = 0;
            end
            exp_valid = exp_q.size() != 0 ? ec >= due_q[0] : 1'b0;
            exp_fire  = reset_n && req_valid && exp_q.size() < DEPTH;
            check(tag("req_ready"), bus.req_ready, reset_n && exp_q.size() < DEPTH);
            check(tag("resp_valid"), bus.resp_valid, exp_valid);
            check(tag("busy"), busy, exp_q.size() != 0);
            check(tag("ram_enb"), ram_enb, exp_fire);
            check(tag("ram_regceb"), ram_regceb, LAT == 2 && prev_fire);
            check(tag("ram_addrb"), ram_addrb, req_addr);
            check(tag("overflow"), u_dut.push && u_dut.count == DEPTH, 1'b0);
            if (exp_valid) check(tag("resp_data"), bus.resp_data, exp_q[0]);
            if (exp_valid && resp_ready) begin
                void'(exp_q.pop_front());
                void'(due_q.pop_front());
            end
            if (exp_fire) begin
                exp_q.push_back(mem[req_addr]);
                due_q.push_back(ec + 1 + LAT);
                fires++;
            end
            prev_fire = exp_fire;
        end
    end

    initial begin
        int n, f0, f1;
        for (int i = 0; i < 2**AW; i++) mem[i] = {$urandom, $urandom};
        repeat (3) step();
        check("reset busy", g_dut[0].busy, 0);
        check("reset req_ready", g_dut[0].bus.req_ready, 0);
        reset_n = 1;
        // single read of address 5
        mem[5] = 64'hA5;
        req_addr = 5; req_valid = 1; resp_ready = 1;
        step();
        req_valid = 0;
        n = 1;
        while (!g_dut[0].bus.resp_valid && n < 20) begin step(); n++; end
        check("single latency", n, 3);
        check("single data", g_dut[0].bus.resp_data, 64'hA5);
        step();
        check("single busy", g_dut[0].busy, 0);
        // back-to-back streaming
        for (int i = 0; i < 16; i++) mem[i] = RW'(i);
        f0 = g_dut[0].fires; f1 = g_dut[1].fires;
        for (int i = 0; i < 16; i++) begin req_valid = 1; req_addr = AW'(i); step(); end
        req_valid = 0;
        check("stream fires L2", g_dut[0].fires - f0, 16);
        check("stream fires L1", g_dut[1].fires - f1, 16);
        repeat (6) step();
        // backpressure fills the credit
        resp_ready = 0;
        f0 = g_dut[0].fires; f1 = g_dut[1].fires;
        for (int i = 0; i < 8; i++) begin req_valid = 1; req_addr = AW'($urandom); step(); end
        check("bp fires L2", g_dut[0].fires - f0, 4);
        check("bp fires L1", g_dut[1].fires - f1, 4);
        check("bp req_ready", g_dut[0].bus.req_ready, 0);
        check("bp count", g_dut[0].u_dut.count, 4);
        resp_ready = 1;
        step();
        resp_ready = 0;
        check("bp ready back L2", g_dut[0].bus.req_ready, 1);
        check("bp ready back L1", g_dut[1].bus.req_ready, 1);
        req_valid = 0; resp_ready = 1;
        repeat (8) step();
        // random traffic
        f0 = g_dut[0].fires; n = 0;
        while (g_dut[0].fires - f0 < 1000 && n < 20000) begin
            req_valid = $urandom_range(0, 3) != 0;
            req_addr = AW'($urandom);
            resp_ready = $urandom_range(0, 1) == 1;
            step();
            n++;
        end
        check("random budget", n < 20000, 1);
        req_valid = 0; resp_ready = 1;
        repeat (8) step();
        check("drain busy L2", g_dut[0].busy, 0);
        check("drain busy L1", g_dut[1].busy, 0);
        // mid-stream asynchronous reset
        resp_ready = 0;
        for (int i = 0; i < 4; i++) begin req_valid = 1; req_addr = AW'(100 + i); step(); end
        check("pre-reset busy", g_dut[0].busy, 1);
        #2 reset_n = 0;
        #1;
        check("async resp_valid L2", g_dut[0].bus.resp_valid, 0);
        check("async busy L2", g_dut[0].busy, 0);
        check("async req_ready L2", g_dut[0].bus.req_ready, 0);
        check("async resp_valid L1", g_dut[1].bus.resp_valid, 0);
        check("async busy L1", g_dut[1].busy, 0);
        check("async req_ready L1", g_dut[1].bus.req_ready, 0);
        req_valid = 0;
        repeat (2) step();
        mem[7] = {$urandom, $urandom};
        reset_n = 1; req_addr = 7; req_valid = 1; resp_ready = 1;
        step();
        req_valid = 0;
        n = 1;
        while (!g_dut[0].bus.resp_valid && n < 20) begin step(); n++; end
        check("post-reset latency", n, 3);
        check("post-reset data", g_dut[0].bus.resp_data, mem[7]);
        step();
        check("post-reset busy L2", g_dut[0].busy, 0);
        check("post-reset resp_valid L1", g_dut[1].bus.resp_valid, 0);
        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
